game_controller: RTL

Top-level sequencer for the game datapath: it generates the one-cycle enables that drive `logic_handler`. These are `startGameEn`, `shipUpdateEn`, `gridUpdateEn` and `gameover_signal`. It paces frames from the 50 MHz clock and hands each frame to the VGA drawer through a `drawEn`/`draw_done` handshake. It watches `ship_health` to end the game and restarts only on a fresh rising edge of the start input.

---
 rtl/game_controller.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/game_controller.sv
// game_controller: top-level sequencer for the game datapath.
//
// Paces frames from the system clock, issues one-cycle enables to logic_handler, hands each
// frame to the VGA drawer through a drawEn/draw_done handshake, and ends the game when
// ship_health reaches zero. A new game starts only on a fresh rising edge of start.
//
// Ports:
//   clk             in   system clock (single domain)
//   reset           in   synchronous, active-high reset
//   start           in   start/restart request (level; only its rising edge is used)
//   ship_health     in   current ship health, sampled only in CHECK
//   draw_done       in   drawer finished the current frame
//   startGameEn     out  clear all game state (one cycle)
//   shipUpdateEn    out  move ship/enemy/cooldown (one cycle per frame)
//   gridUpdateEn    out  shift bullet grid (one cycle every GRID_DIV frames)
//   drawEn          out  frame-draw request, held until draw_done
//   gameover_signal out  one-cycle pulse in the first OVER cycle
//   frame_overrun   out  sticky: a frame tick arrived while a frame was still in progress
//   state           out  current FSM state (debug / HEX display)
module game_controller #(
  parameter int unsigned FRAME_DIV = 833333,
  parameter int unsigned GRID_DIV  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] ship_health,
  input  logic       draw_done,
  output logic       startGameEn,
  output logic       shipUpdateEn,
  output logic       gridUpdateEn,
  output logic       drawEn,
  output logic       gameover_signal,
  output logic       frame_overrun,
  output logic [2:0] state
);

  localparam int unsigned FW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam int unsigned GW = (GRID_DIV > 1) ? $clog2(GRID_DIV) : 1;
  localparam logic [FW-1:0] FLast = FW'(FRAME_DIV - 1);
  localparam logic [GW-1:0] GLast = GW'(GRID_DIV - 1);

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StStart     = 3'd1,
    StWaitFrame = 3'd2,
    StShip      = 3'd3,
    StGrid      = 3'd4,
    StDraw      = 3'd5,
    StCheck     = 3'd6,
    StOver      = 3'd7
  } state_e;

  state_e        state_q, state_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic [GW-1:0] gcnt_q, gcnt_d;
  logic          start_q;
  logic          overrun_q, overrun_d;
  logic          gameover_q, gameover_d;
  logic          tick;
  logic          start_rise;
  logic          in_frame;

  always_comb begin
    tick       = (fcnt_q == FLast);
    start_rise = start & ~start_q;
    in_frame   = (state_q == StShip) || (state_q == StGrid) ||
                 (state_q == StDraw) || (state_q == StCheck);

    state_d    = state_q;
    fcnt_d     = tick ? '0 : fcnt_q + 1'b1;
    gcnt_d     = gcnt_q;
    overrun_d  = overrun_q;
    gameover_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_rise) state_d = StStart;
      end
      StStart: begin
        // Realign the frame grid to the start of the game.
        state_d   = StWaitFrame;
        fcnt_d    = '0;
        gcnt_d    = '0;
        overrun_d = 1'b0;
      end
      StWaitFrame: begin
        if (tick) state_d = StShip;
      end
      StShip: begin
        if (gcnt_q == GLast) begin
          state_d = StGrid;
          gcnt_d  = '0;
        end else begin
          state_d = StDraw;
          gcnt_d  = gcnt_q + 1'b1;
        end
      end
      StGrid: begin
        state_d = StDraw;
      end
      StDraw: begin
        if (draw_done) state_d = StCheck;
      end
      StCheck: begin
        if (ship_health == 4'd0) begin
          state_d    = StOver;
          gameover_d = 1'b1;
        end else begin
          state_d = StWaitFrame;
        end
      end
      StOver: begin
        if (start_rise) state_d = StStart;
      end
    endcase

    // A tick while a frame is still being processed is dropped, not queued.
    if (tick && in_frame) overrun_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      fcnt_q     <= '0;
      gcnt_q     <= '0;
      overrun_q  <= 1'b0;
      gameover_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fcnt_q     <= fcnt_d;
      gcnt_q     <= gcnt_d;
      overrun_q  <= overrun_d;
      gameover_q <= gameover_d;
    end
  end

  // start_q tracks start even during reset, so a start held high across reset release is
  // not mistaken for a fresh rising edge; it reads 0 whenever start is low in reset.
  always_ff @(posedge clk) begin
    start_q <= start;
  end

  always_comb begin
    startGameEn     = (state_q == StStart);
    shipUpdateEn    = (state_q == StShip);
    gridUpdateEn    = (state_q == StGrid);
    drawEn          = (state_q == StDraw);
    gameover_signal = gameover_q;
    frame_overrun   = overrun_q;
    state           = state_q;
  end

endmodule
